// File: rtl/ser2par_framer_if.sv
// ser2par_framer_if
// Bundles the serial bit stream going into the framer and the parallel word,
// status pulses and good-word counter coming back out of it.
//   serial_in   : serial data bit, only meaningful when bit_valid is high
//   bit_valid   : qualifies serial_in (and sync) for the current cycle
//   sync        : start-of-frame marker, current bit is the data MSB
//   Data_out    : last good assembled word
//   load        : one-cycle pulse, Data_out is new this cycle
//   parity_err  : one-cycle pulse on a bad parity bit
//   frame_abort : one-cycle pulse when a frame in progress is restarted
//   busy        : high while a frame is being assembled
//   word_cnt    : count of good words, wraps silently
// master = bit stream source, slave = framer.
interface ser2par_framer_if #(
    parameter int word_size = 4,
    parameter int cnt_width = 8
);
    logic                 serial_in;
    logic                 bit_valid;
    logic                 sync;
    logic [word_size-1:0] Data_out;
    logic                 load;
    logic                 parity_err;
    logic                 frame_abort;
    logic                 busy;
    logic [cnt_width-1:0] word_cnt;

    modport master (
        output serial_in, bit_valid, sync,
        input  Data_out, load, parity_err, frame_abort, busy, word_cnt
    );

    modport slave (
        input  serial_in, bit_valid, sync,
        output Data_out, load, parity_err, frame_abort, busy, word_cnt
    );
endinterface

// File: rtl/ser2par_framer.sv
// ser2par_framer
// Assembles a sync-marked, MSB-first serial data field followed by one even
// parity bit into a parallel word for a downstream parallel-load register.
// A good frame updates Data_out and pulses load for one cycle; a bad parity
// bit pulses parity_err; a sync arriving mid-frame pulses frame_abort and
// restarts assembly with the current bit as the new MSB.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : ser2par_framer_if slave modport (stream in, word/status out)
module ser2par_framer #(
    parameter int word_size = 4,
    parameter int cnt_width = 8
) (
    input  logic               clock,
    input  logic               reset,
    ser2par_framer_if.slave    bus
);

    localparam int CW = $clog2(word_size + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(word_size);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [word_size-1:0] shreg;
    logic [word_size-1:0] shreg_next;
    logic [CW-1:0]        bitcnt;
    logic [CW-1:0]        bitcnt_next;
    logic [CW-1:0]        bitcnt_inc;
    logic [word_size-1:0] data_next;
    logic [cnt_width-1:0] cnt_next;
    logic                 load_next;
    logic                 perr_next;
    logic                 abort_next;

    assign bitcnt_inc = bitcnt + CW'(1);
    assign bus.busy   = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath decisions. Nothing moves on cycles without
    // bit_valid, and the pulse outputs default low so they last one cycle.
    always_comb begin
        state_next  = state;
        shreg_next  = shreg;
        bitcnt_next = bitcnt;
        data_next   = bus.Data_out;
        cnt_next    = bus.word_cnt;
        load_next   = 1'b0;
        perr_next   = 1'b0;
        abort_next  = 1'b0;

        if (bus.bit_valid) begin
            if (bus.sync) begin
                // A sync always starts a new frame; if one was already in
                // progress it is thrown away and reported as aborted. A
                // single-bit word has no data phase beyond the MSB.
                abort_next  = (state != IDLE);
                shreg_next  = word_size'(bus.serial_in);
                bitcnt_next = CW'(1);
                state_next  = (word_size == 1) ? PARITY : DATA;
            end else begin
                case (state)
                    IDLE: begin
                        state_next = IDLE;
                    end
                    DATA: begin
                        shreg_next  = (shreg << 1) | word_size'(bus.serial_in);
                        bitcnt_next = bitcnt_inc;
                        if (bitcnt_inc == LAST_BIT) begin
                            state_next = PARITY;
                        end
                    end
                    PARITY: begin
                        // Even parity: data bits plus parity bit XOR to zero.
                        if ((^shreg ^ bus.serial_in) == 1'b0) begin
                            data_next = shreg;
                            cnt_next  = bus.word_cnt + cnt_width'(1);
                            load_next = 1'b1;
                        end else begin
                            perr_next = 1'b1;
                        end
                        bitcnt_next = '0;
                        state_next  = IDLE;
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg           <= '0;
            bitcnt          <= '0;
            bus.Data_out    <= '0;
            bus.word_cnt    <= '0;
            bus.load        <= 1'b0;
            bus.parity_err  <= 1'b0;
            bus.frame_abort <= 1'b0;
        end else begin
            shreg           <= shreg_next;
            bitcnt          <= bitcnt_next;
            bus.Data_out    <= data_next;
            bus.word_cnt    <= cnt_next;
            bus.load        <= load_next;
            bus.parity_err  <= perr_next;
            bus.frame_abort <= abort_next;
        end
    end

endmodule
